// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 adder (IDLE/ALIGN/ADD/NORM/DONE) with valid/ready on both sides.
// Denormals flush to zero, results truncate, NaN inputs behave as Inf.
module fp_add_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int M          = 23,
  parameter int E          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out
);

  localparam int LZW = $clog2(M + 2);
  localparam logic signed [E+1:0] EXP_MAX = (E+2)'((1 << E) - 1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg;
  logic [M:0]              l_mant_reg, s_mant_reg;
  logic [E-1:0]            l_exp_reg;
  logic                    l_sign_reg, s_sign_reg;
  logic                    inf_reg, nan_reg, inf_sign_reg;
  logic [M+1:0]            sum_reg;

  // Operand decode and alignment
  logic [E-1:0] a_exp, b_exp, big_exp, small_exp, exp_diff;
  logic [M:0]   a_mant, b_mant, big_mant, small_mant, small_shifted;
  logic         a_sign, b_sign, a_inf, b_inf, a_is_big;

  always_comb begin
    a_sign   = a_reg[DATA_WIDTH-1];
    b_sign   = b_reg[DATA_WIDTH-1];
    a_exp    = a_reg[DATA_WIDTH-2 -: E];
    b_exp    = b_reg[DATA_WIDTH-2 -: E];
    a_inf    = &a_exp;
    b_inf    = &b_exp;
    a_mant   = (a_exp == '0) ? '0 : {1'b1, a_reg[M-1:0]};
    b_mant   = (b_exp == '0) ? '0 : {1'b1, b_reg[M-1:0]};
    a_is_big = {a_exp, a_mant} >= {b_exp, b_mant};
    big_exp    = a_is_big ? a_exp  : b_exp;
    small_exp  = a_is_big ? b_exp  : a_exp;
    big_mant   = a_is_big ? a_mant : b_mant;
    small_mant = a_is_big ? b_mant : a_mant;
    exp_diff   = big_exp - small_exp;
    if (int'(exp_diff) >= M + 1)
      small_shifted = '0;
    else
      small_shifted = small_mant >> exp_diff;
  end

  // Normalisation: leading-zero count over the non-carry part of the sum
  logic [LZW-1:0]        lzc;
  logic [M:0]            norm_shifted;
  logic [M-1:0]          res_frac;
  logic signed [E+1:0]   res_exp;
  logic [DATA_WIDTH-1:0] result;

  always_comb begin
    lzc = '0;
    for (int i = 0; i <= M; i++)
      if (sum_reg[i]) lzc = LZW'(M - i);
    norm_shifted = sum_reg[M:0] << lzc;
    if (sum_reg[M+1]) begin
      res_exp  = signed'({2'b00, l_exp_reg}) + (E+2)'(1);
      res_frac = sum_reg[M:1];
    end else begin
      res_exp  = signed'({2'b00, l_exp_reg}) - signed'({{(E+2-LZW){1'b0}}, lzc});
      res_frac = norm_shifted[M-1:0];
    end

    if (nan_reg)
      result = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    else if (inf_reg)
      result = {inf_sign_reg, {E{1'b1}}, {M{1'b0}}};
    else if (sum_reg == '0)
      result = '0;
    else if (res_exp >= EXP_MAX)
      result = {l_sign_reg, {E{1'b1}}, {M{1'b0}}};
    else if (res_exp <= 0)
      result = '0;
    else
      result = {l_sign_reg, res_exp[E-1:0], res_frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      l_mant_reg   <= '0;
      s_mant_reg   <= '0;
      l_exp_reg    <= '0;
      l_sign_reg   <= 1'b0;
      s_sign_reg   <= 1'b0;
      inf_reg      <= 1'b0;
      nan_reg      <= 1'b0;
      inf_sign_reg <= 1'b0;
      sum_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg     <= in1;
            b_reg     <= in2;
            in_ready  <= 1'b0;
            state_reg <= ALIGN;
          end
        end
        ALIGN: begin
          l_mant_reg   <= big_mant;
          s_mant_reg   <= small_shifted;
          l_exp_reg    <= big_exp;
          l_sign_reg   <= a_is_big ? a_sign : b_sign;
          s_sign_reg   <= a_is_big ? b_sign : a_sign;
          inf_reg      <= a_inf | b_inf;
          nan_reg      <= a_inf & b_inf & (a_sign ^ b_sign);
          inf_sign_reg <= a_inf ? a_sign : b_sign;
          state_reg    <= ADD;
        end
        ADD: begin
          // L >= S by construction, so the difference never goes negative
          if (l_sign_reg == s_sign_reg)
            sum_reg <= {1'b0, l_mant_reg} + {1'b0, s_mant_reg};
          else
            sum_reg <= {1'b0, l_mant_reg} - {1'b0, s_mant_reg};
          state_reg <= NORM;
        end
        NORM: begin
          out       <= result;
          out_valid <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
